// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader and port arbiter.
// Assembles a little-endian byte stream into 32-bit words and writes them
// from word 0 upward, then hands the memory port to the CPU fetch path.
module imem_boot_loader #(
    parameter int DEPTH = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic        cpu_stall_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN
    } state_t;

    localparam logic [8:0]  DEPTH_LEN   = 9'(DEPTH);
    localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

    state_t      state;
    logic [7:0]  len_q;
    logic [7:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;

    logic len_zero;
    logic len_over;
    logic pc_ok;

    assign len_zero = (len_i == 8'd0);
    assign len_over = ({1'b0, len_i} > DEPTH_LEN);
    assign pc_ok    = (pc_i[31:2] < DEPTH_WORDS) && (pc_i[1:0] == 2'b00);

    // NOTE: the fetch path is deliberately combinational (pc -> address ->
    // read data -> instruction in one cycle); only the load side is registered.
    assign mem_addr_o = (state == RUN) ? pc_i : {22'd0, word_idx, 2'b00};
    assign instr_o    = (state == RUN && pc_ok) ? mem_rdata_i : 32'd0;

    // Load/run sequencer with registered handshake and status outputs.
    // NOTE: the instruction memory lives outside this block, so an
    // asynchronous reset never disturbs words that were already written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            len_q        <= 8'd0;
            word_idx     <= 8'd0;
            byte_cnt     <= 2'd0;
            asm_q        <= 24'd0;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_wdata_o  <= 32'd0;
            cpu_stall_o  <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            // NOTE: every state register here uses <= so all updates in this
            // block see the pre-edge values, independent of statement order.
            case (state)
                IDLE, RUN: begin
                    if (state == RUN && !pc_ok) begin
                        err_o <= 1'b1;
                    end
                    if (start_i) begin
                        if (len_over) begin
                            err_o <= 1'b1;
                        end else if (len_zero) begin
                            state       <= RUN;
                            done_o      <= 1'b1;
                            cpu_stall_o <= 1'b0;
                        end else begin
                            state        <= LOAD;
                            len_q        <= len_i;
                            word_idx     <= 8'd0;
                            byte_cnt     <= 2'd0;
                            byte_ready_o <= 1'b1;
                            busy_o       <= 1'b1;
                            done_o       <= 1'b0;
                            cpu_stall_o  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (byte_valid_i && byte_ready_o) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata_o  <= {byte_data_i, asm_q};
                            mem_we_o     <= 1'b1;
                            byte_ready_o <= 1'b0;
                            state        <= WRITE;
                        end else begin
                            asm_q[8*byte_cnt +: 8] <= byte_data_i;
                        end
                    end
                end

                WRITE: begin
                    mem_we_o <= 1'b0;
                    word_idx <= word_idx + 8'd1;
                    if (word_idx + 8'd1 == len_q) begin
                        state       <= RUN;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        cpu_stall_o <= 1'b0;
                    end else begin
                        state        <= LOAD;
                        byte_cnt     <= 2'd0;
                        byte_ready_o <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed loads, run-time fetches,
// error cases, mid-load restarts and asynchronous reset.
module tb_imem_boot_loader;

    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic [31:0] pc_i;
    logic [31:0] instr_o;
    logic        cpu_stall_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    imem_boot_loader #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i (byte_data_i),
        .byte_ready_o(byte_ready_o),
        .pc_i        (pc_i),
        .instr_o     (instr_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Instruction memory attached to the DUT port.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[AW+1:2]] <= mem_wdata_o;
    end
    assign mem_rdata_i = (mem_addr_o[31:2] < DEPTH) ? mem[mem_addr_o[AW+1:2]] : 32'hDEAD_BEEF;

    // Reference image: what memory must hold, built only from expected writes.
    logic [31:0] ref_mem [DEPTH];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t cur;
    int  we_cyc[$];
    int  checks   = 0;
    int  errors   = 0;
    int  cyc      = 0;
    int  we_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        if (pc[31:2] < DEPTH && pc[1:0] == 2'b00) return ref_mem[pc[AW+1:2]];
        return 32'd0;
    endfunction

    always @(posedge clk) cyc++;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mem_we_o) begin
            we_count++;
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr_o, mem_wdata_o);
            end else begin
                cur = exp_q.pop_front();
                check("write_addr", mem_addr_o, cur.addr);
                check("write_data", mem_wdata_o, cur.data);
                check("ready_low_in_write", byte_ready_o, 0);
                ref_mem[cur.addr[AW+1:2]] = cur.data;
            end
        end
        check("stall_is_not_done", cpu_stall_o, !done_o);
        check("busy_and_done_exclusive", busy_o & done_o, 0);
        if (done_o) begin
            check("run_addr_passthrough", mem_addr_o, pc_i);
            check("run_instr", instr_o, model_instr(pc_i));
        end else begin
            check("stalled_nop", instr_o, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (byte_ready_o) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: byte %h not accepted within 50 cycles", b);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        int gap;
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) begin
                gap = int'($urandom_range(0, max_gap));
                byte_valid_i = 1'b0;
                byte_data_i  = 8'hXX;
                repeat (gap) tick();
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", done_o, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, byte_ready_o, 0);
        check({tag, "_mem_we"}, mem_we_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_instr"}, instr_o, 0);
        check({tag, "_stall"}, cpu_stall_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    // Mid-cycle reset pulse, checked before the next clock edge.
    task automatic apply_reset(input string tag);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_vals(tag);
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c_n;
        int          wc0;
        logic [31:0] words [DEPTH];
        logic [31:0] w1;
        logic [31:0] v [5];

        rst_i        = 1'b1;
        start_i      = 1'b0;
        len_i        = 8'd0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;
        pc_i         = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        #1;
        check_reset_vals("por");
        repeat (2) tick();
        rst_i = 1'b0;
        tick();

        // Two-word load with valid held high: exact write and done timing.
        exp_q.push_back('{addr: 32'd0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 32'd4, data: 32'h0010_0093});
        we_cyc.delete();
        do_start(8'd2);
        c_n = cyc;
        check("load_ready_cycle1", byte_ready_o, 1);
        check("load_busy_cycle1", busy_o, 1);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        check("second_write_cycle", cyc - c_n + 1, 10);
        check("second_write_we", mem_we_o, 1);
        check("second_write_addr", mem_addr_o, 32'd4);
        check("second_write_data", mem_wdata_o, 32'h0010_0093);
        byte_valid_i = 1'b0;
        tick();
        check("done_cycle11", done_o, 1);
        check("unstall_cycle11", cpu_stall_o, 0);
        check("write_pulse_count", we_cyc.size(), 2);
        check("first_write_cycle", we_cyc[0] - c_n + 1, 5);

        // Run-time fetches, including an out-of-range word.
        pc_i = 32'd4;
        #1;
        check("fetch4_addr", mem_addr_o, 32'd4);
        check("fetch4_instr", instr_o, 32'h0010_0093);
        pc_i = 32'd0;
        #1;
        check("fetch0_instr", instr_o, 32'h0000_0013);
        check("err_before_bad_pc", err_o, 0);
        pc_i = 32'h200;
        #1;
        check("bad_pc_nop", instr_o, 0);
        tick();
        check("bad_pc_err", err_o, 1);
        pc_i = 32'd0;
        apply_reset("rst1");

        // Oversized length from IDLE, then zero length.
        wc0 = we_count;
        do_start(8'd129);
        check("len129_err", err_o, 1);
        check("len129_ready", byte_ready_o, 0);
        check("len129_busy", busy_o, 0);
        check("len129_done", done_o, 0);
        repeat (3) tick();
        check("len129_ready_later", byte_ready_o, 0);
        check("len129_no_writes", we_count - wc0, 0);
        do_start(8'd0);
        check("len0_done", done_o, 1);
        check("len0_unstall", cpu_stall_o, 0);
        pc_i = 32'd4;
        #1;
        check("len0_mem_unchanged", instr_o, 32'h0010_0093);
        pc_i = 32'd0;

        // Full-depth reload from RUN with random stream gaps.
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = $urandom;
            exp_q.push_back('{addr: 32'(i * 4), data: words[i]});
        end
        wc0 = we_count;
        do_start(8'(DEPTH));
        check("reload_stall", cpu_stall_o, 1);
        check("reload_done_low", done_o, 0);
        check("reload_ready", byte_ready_o, 1);
        for (int i = 0; i < DEPTH; i++) send_word(words[i], 2);
        byte_valid_i = 1'b0;
        wait_done(20);
        check("full_write_count", we_count - wc0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            pc_i = 32'(i * 4);
            tick();
        end
        pc_i = 32'd508;
        #1;
        check("full_last_word", instr_o, words[DEPTH-1]);
        pc_i = 32'd0;

        // start_i during LOAD with a different length is ignored.
        w1 = 32'h0BAD_F00D;
        exp_q.push_back('{addr: 32'd0, data: 32'hA1B2_C3D4});
        exp_q.push_back('{addr: 32'd4, data: w1});
        exp_q.push_back('{addr: 32'd8, data: 32'h1234_5678});
        do_start(8'd3);
        send_word(32'hA1B2_C3D4, 0);
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        byte_valid_i = 1'b0;
        tick();
        do_start(8'd1);
        check("midload_start_busy", busy_o, 1);
        check("midload_start_done", done_o, 0);
        send_byte(w1[23:16]);
        send_byte(w1[31:24]);
        byte_valid_i = 1'b0;
        tick();
        check("after_word1_not_done", done_o, 0);
        check("after_word1_busy", busy_o, 1);
        send_word(32'h1234_5678, 0);
        byte_valid_i = 1'b0;
        wait_done(10);
        pc_i = 32'd8;
        #1;
        check("len3_word2", instr_o, 32'h1234_5678);
        pc_i = 32'd0;

        // Asynchronous reset after two bytes of word 3.
        for (int i = 0; i < 5; i++) v[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: 32'(i * 4), data: v[i]});
        do_start(8'd5);
        for (int i = 0; i < 3; i++) send_word(v[i], 1);
        send_byte(v[3][7:0]);
        send_byte(v[3][15:8]);
        byte_valid_i = 1'b0;
        check("pre_abort_pending_writes", exp_q.size(), 0);
        exp_q.delete();
        apply_reset("abort");
        repeat (3) tick();
        check("post_abort_stall", cpu_stall_o, 1);
        check("post_abort_done", done_o, 0);
        exp_q.push_back('{addr: 32'd0, data: 32'hFEED_0001});
        do_start(8'd1);
        send_word(32'hFEED_0001, 0);
        byte_valid_i = 1'b0;
        wait_done(10);
        pc_i = 32'd0;
        #1;
        check("fresh_word0", instr_o, 32'hFEED_0001);
        pc_i = 32'd4;
        #1;
        check("words_kept_after_abort", instr_o, v[1]);
        pc_i = 32'd0;
        tick();

        check("expected_writes_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
